// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;

  // Values for the SDA pull-down during an acknowledge slot.
  localparam logic ACK  = 1'b1;
  localparam logic NACK = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } i2c_rx_state_t;

  // True when an address byte selects this slave for a write (R/W bit = 0).
  function automatic logic is_write_to(input logic [BYTE_W-1:0] addr_byte,
                                       input logic [ADDR_W-1:0] slave_addr);
    return (addr_byte[BYTE_W-1:1] == slave_addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// Combinational SCL edge and START/STOP condition detector.
module i2c_bus_cond (
  input  logic i_scl,
  input  logic i_scl_prev,
  input  logic i_sda,
  input  logic i_sda_prev,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  assign o_scl_rise = i_scl & ~i_scl_prev;
  assign o_scl_fall = ~i_scl & i_scl_prev;
  // SDA may only change while SCL is high to signal START (fall) or STOP (rise).
  assign o_start    = i_scl & i_scl_prev & i_sda_prev & ~i_sda;
  assign o_stop     = i_scl & i_scl_prev & ~i_sda_prev & i_sda;

endmodule

// File: rtl/i2c_slave_write_rx.sv
// I2C slave write receiver: address match, per-byte ACK/NACK and a
// valid/ready byte stream with backpressure and a per-transaction byte limit.
module i2c_slave_write_rx
  import i2c_pkg::*;
#(
  parameter int unsigned       NUM_BYTES  = 6,
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h42,
  parameter int unsigned       CNT_W      = $clog2(NUM_BYTES + 1)
) (
  input  logic              FPGA_clk,
  input  logic              rst,
  input  logic              SCL,
  input  logic              SCL_prev,
  input  logic              SDA,
  input  logic              SDA_prev,
  input  logic              enable,
  output logic              SDA_down,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [CNT_W-1:0]  byte_count,
  output logic              addr_match,
  output logic              done,
  output logic              nack_err
);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_bus_cond u_bus_cond (
    .i_scl      (SCL),
    .i_scl_prev (SCL_prev),
    .i_sda      (SDA),
    .i_sda_prev (SDA_prev),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_rx_state_t     r_state;
  logic [BYTE_W-1:0] r_shift;
  logic [3:0]        r_bit_cnt;
  logic              r_sda_down;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic [CNT_W-1:0]  r_byte_count;
  logic              r_addr_match;
  logic              r_done;
  logic              r_nack_err;

  logic w_bus_start;
  logic w_bus_stop;
  logic w_byte_end;
  logic w_addr_ack;
  logic w_data_ack;

  // Bus conditions are ignored while we hold SDA low ourselves.
  assign w_bus_start = w_start & ~r_sda_down;
  assign w_bus_stop  = w_stop & ~r_sda_down;
  assign w_byte_end  = (r_bit_cnt == 4'd8) & w_scl_fall;
  assign w_addr_ack  = is_write_to(r_shift, SLAVE_ADDR);
  // Room left in this transaction and the output slot free (or emptying now).
  assign w_data_ack  = (r_byte_count < CNT_W'(NUM_BYTES)) & (~r_rx_valid | rx_ready);

  // Receive FSM, shift register and output stream registers.
  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sda_down   <= NACK;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_byte_count <= '0;
      r_addr_match <= 1'b0;
      r_done       <= 1'b0;
      r_nack_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (!enable) begin
        // Pending rx byte is kept; only the bus side is abandoned.
        r_state      <= StIdle;
        r_sda_down   <= NACK;
        r_addr_match <= 1'b0;
      end else if (w_bus_stop) begin
        if (r_state != StIdle && r_byte_count != '0) begin
          r_done <= 1'b1;
        end
        r_state      <= StIdle;
        r_sda_down   <= NACK;
        r_addr_match <= 1'b0;
      end else if (w_bus_start) begin
        // Covers both a fresh START from idle and a repeated START.
        r_state      <= StAddr;
        r_bit_cnt    <= '0;
        r_byte_count <= '0;
        r_nack_err   <= 1'b0;
        r_addr_match <= 1'b0;
        r_sda_down   <= NACK;
      end else begin
        case (r_state)
          StAddr, StData: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= {r_shift[BYTE_W-2:0], SDA};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_byte_end) begin
              if (r_state == StAddr) begin
                r_state      <= StAddrAck;
                r_sda_down   <= w_addr_ack ? ACK : NACK;
                r_addr_match <= w_addr_ack;
              end else if (w_data_ack) begin
                r_state      <= StDataAck;
                r_sda_down   <= ACK;
                r_rx_data    <= r_shift;
                r_rx_valid   <= 1'b1;
                r_byte_count <= r_byte_count + CNT_W'(1);
              end else begin
                r_state    <= StIgnore;
                r_nack_err <= 1'b1;
              end
            end
          end
          StAddrAck: begin
            if (w_scl_fall) begin
              r_sda_down <= NACK;
              r_bit_cnt  <= '0;
              r_state    <= r_addr_match ? StData : StIgnore;
            end
          end
          StDataAck: begin
            if (w_scl_fall) begin
              r_sda_down <= NACK;
              r_bit_cnt  <= '0;
              r_state    <= StData;
            end
          end
          default: begin
            // StIdle and StIgnore only react to START/STOP above.
          end
        endcase
      end
    end
  end

  assign SDA_down   = r_sda_down;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign byte_count = r_byte_count;
  assign addr_match = r_addr_match;
  assign done       = r_done;
  assign nack_err   = r_nack_err;

endmodule

// File: doc/i2c_slave_write_rx.md
Name: i2c_slave_write_rx

Overview:
- Parametrised successor to the single-transaction I2C data-in decoder.
- Adds START/STOP/repeated-START detection, 7-bit address match, R/W decode and per-byte ACK/NACK generation.
- Adds a valid/ready byte stream with backpressure (NACK when the consumer is not ready) and a configurable per-transaction byte limit.
- Sits between the SCL/SDA pad samplers and the slave register file / display logic.

Parameters:
- NUM_BYTES, 6: maximum data bytes ACKed per transaction; later bytes are NACKed.
- SLAVE_ADDR, 7'h42: 7-bit address this slave answers.
- CNT_W, $clog2(NUM_BYTES+1): width of the byte counter.

Ports:
- FPGA_clk  in  1  system clock; SCL/SDA are oversampled on this clock.
- rst  in  1  synchronous, active-high reset.
- SCL  in  1  synchronised SCL sample.
- SCL_prev  in  1  SCL sample from the previous FPGA_clk cycle.
- SDA  in  1  synchronised SDA sample.
- SDA_prev  in  1  SDA sample from the previous FPGA_clk cycle.
- enable  in  1  when low, the block holds in IDLE and ignores the bus.
- SDA_down  out  1  high = pull SDA low (ACK drive); low = release.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data is valid; held until rx_ready.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- byte_count  out  CNT_W  data bytes ACKed in the current or most recent transaction.
- addr_match  out  1  high from an ACKed address until STOP or START.
- done  out  1  one-cycle pulse on STOP when byte_count > 0.
- nack_err  out  1  sticky; set on any data-byte NACK; cleared by rst or a new START.

Behaviour:
- Reset state: all outputs 0; FSM = IDLE; shift register, bit counter and byte_count = 0.
- Edge qualifiers (same-cycle combinational):
  - scl_rise = SCL & ~SCL_prev
  - scl_fall = ~SCL & SCL_prev
  - start = SCL & SCL_prev & SDA_prev & ~SDA
  - stop = SCL & SCL_prev & ~SDA_prev & SDA
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: on start with enable = 1, go to ADDR; clear byte_count, nack_err and bit counter.
- ADDR / DATA:
  - On scl_rise, shift SDA into the LSB of the shift register (MSB first) and increment the bit counter.
  - After the 8th rise, on the next scl_fall, move to the matching ACK state.
- ADDR_ACK:
  - Entered on scl_fall. If shift[7:1] == SLAVE_ADDR and shift[0] == 0 (write): assert SDA_down and addr_match.
  - Otherwise, leave SDA_down low.
  - On the following scl_fall: release SDA_down, reset the bit counter, go to DATA if matched, else IGNORE.
  - Reads (R/W = 1) are not supported and are NACKed.
- DATA_ACK: ACK (SDA_down = 1) iff byte_count < NUM_BYTES and the rx slot is free (rx_valid == 0, or handshake in this same cycle).
  - On ACK: rx_data = shift, rx_valid = 1, byte_count += 1.
  - On NACK: rx_valid and byte_count unchanged; nack_err = 1; next state IGNORE.
  - On ACK, the following scl_fall releases SDA_down and returns to DATA.
- IGNORE: SDA_down = 0; wait for start or stop.
- rx_valid clears one cycle after rx_valid && rx_ready; rx_data is stable while rx_valid = 1.
- Priority: start/stop override every state in the same cycle.
  - stop: go to IDLE, release SDA_down, clear addr_match, pulse done if byte_count > 0.
  - start in any non-IDLE state (repeated START): go to ADDR, clear byte_count.
  - A pending rx_valid byte survives both stop and start.
- Glitch rule: start/stop are not evaluated while SDA_down = 1. The slave's own drive is not a condition.
- enable low mid-transfer: release SDA_down and go to IDLE on the next cycle; rx_valid is retained.
- rst mid-transfer: everything returns to reset values on the next FPGA_clk edge, including a pending rx_valid.
- byte_count saturates at NUM_BYTES.

Decomposition:
- Package i2c_pkg: state enum i2c_rx_state_t; localparams for ADDR_W = 7 and BYTE_W = 8; ACK/NACK constants.
- Sub-module i2c_bus_cond: edge and start/stop detector. Inputs SCL, SCL_prev, SDA, SDA_prev; outputs scl_rise, scl_fall, start, stop. It is purely combinational and will be reused by the slave transmitter.
- The FSM, shift register and output stream stay in i2c_slave_write_rx.

Test Plan:
- START, addr 0x42 + W, data 0xA5, 0x3C, STOP, rx_ready = 1:
  - ACK on the address and both data bytes.
  - rx_data is 0xA5, then 0x3C.
  - byte_count = 2; done pulses once; nack_err = 0.
- START, addr 0x43 + W, one byte, STOP:
  - SDA_down never asserts; addr_match = 0; rx_valid never rises; no done pulse.
- addr 0x42 + R:
  - NACK on the address; block goes to IGNORE; a subsequent STOP returns it to IDLE with no done pulse.
- rx_ready = 0, two data bytes:
  - First byte is ACKed and held in rx_valid.
  - Second byte is NACKed; nack_err = 1; rx_data stays at the first byte until rx_ready rises.
- NUM_BYTES = 6, 7 data bytes with rx_ready = 1:
  - Bytes 1–6 are ACKed; the 7th is NACKed.
  - byte_count = 6; done pulses on STOP.
- Repeated START after 2 bytes, then addr 0x42 + W, 1 byte, STOP:
  - byte_count goes to 0, then 1; one done pulse.
  - Variant: rst asserted mid-byte forces all outputs to 0 on the next FPGA_clk edge.
